// File: rtl/fetch_sequencer.sv
// fetch_sequencer: two-byte instruction fetch controller with PC, IR byte strobes and wait-state watchdog
module fetch_sequencer #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int MAX_WAIT = 15
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              MemReady,
  input  logic              ExecDone,
  input  logic              Branch,
  input  logic [ADDR_W-1:0] BranchTarget,
  output logic              MemRead,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              IR_LH,
  output logic              IR_Write,
  output logic              InstrValid,
  output logic [ADDR_W-1:0] PC,
  output logic              TimeoutErr
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  typedef enum logic [2:0] {IDLE, FETCH_LO, FETCH_HI, ISSUE, FAULT} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic fetch;
  assign fetch      = state_q == FETCH_LO || state_q == FETCH_HI;
  assign MemRead    = fetch;
  assign MemAddr    = pc_q;
  assign PC         = pc_q;
  assign IR_LH      = state_q == FETCH_HI;
  assign IR_Write   = fetch & MemReady & ~Reset;
  assign InstrValid = state_q == ISSUE;
  assign TimeoutErr = err_q;
  // next state, PC advance and wait counter; counter is zero outside a stalled fetch
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = '0;
    err_d   = err_q;
    case (state_q)
      IDLE: if (Enable) state_d = FETCH_LO;
      FETCH_LO, FETCH_HI:
        if (MemReady) begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = state_q == FETCH_LO ? FETCH_HI : ISSUE;
        end else if (cnt_q == CW'(MAX_WAIT)) begin
          state_d = FAULT;
          err_d   = 1'b1;
        end else cnt_d = cnt_q + CW'(1);
      ISSUE:
        if (ExecDone) begin
          if (Branch) pc_d = BranchTarget;
          state_d = Enable ? FETCH_LO : IDLE;
        end
      default: ;
    endcase
  end
  // state registers with synchronous reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Two-byte instruction fetch controller for the 16-bit instruction register, which is loaded one byte at a time through its low/high select and write-enable inputs. The block owns the program counter and reads bytes from an 8-bit memory port with a ready handshake. It drives the register's half-select and write strobe, then holds the assembled instruction for the execute stage until that stage reports completion. A wait-state watchdog traps hung memory accesses.

## Interface
- ADDR_W, 8, program-counter and memory-address width
- RESET_PC, 0, PC value after reset
- MAX_WAIT, 15, cycles a fetch may wait for MemReady before faulting (≥1)

- Clock  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- Enable  in  1  permits starting a new fetch
- MemReady  in  1  memory byte valid on the bus this cycle
- ExecDone  in  1  execute stage has finished the instruction held in IR
- Branch  in  1  qualifies BranchTarget; sampled only with ExecDone in ISSUE
- BranchTarget  in  ADDR_W  next-instruction address on a taken branch
- MemRead  out  1  memory read request
- MemAddr  out  ADDR_W  byte address, equal to PC
- IR_LH  out  1  IR half select: 0 = bits [7:0], 1 = bits [15:8]
- IR_Write  out  1  IR write strobe; IR latches the byte on the same edge
- InstrValid  out  1  IR holds a complete instruction
- PC  out  ADDR_W  current program counter
- TimeoutErr  out  1  sticky watchdog fault flag

## Operation
- States: IDLE, FETCH_LO, FETCH_HI, ISSUE, FAULT. Reset forces IDLE, PC=RESET_PC, wait counter=0, TimeoutErr=0.
- Outputs are decoded from state (Moore), except IR_Write:
  - MemRead=1 in FETCH_LO/FETCH_HI, otherwise 0.
  - MemAddr=PC at all times.
  - IR_LH=1 only in FETCH_HI.
  - IR_Write = MemRead & MemReady & ~Reset.
  - InstrValid=1 only in ISSUE.
  - All outputs are 0 in IDLE, except PC and MemAddr.
- IDLE: Enable=1 → FETCH_LO.
- FETCH_LO: on MemReady, the low byte is written, PC←PC+1 and the state goes to FETCH_HI. Otherwise the wait counter increments.
- FETCH_HI: same as FETCH_LO with IR_LH=1; on MemReady, PC←PC+1 and the state goes to ISSUE.
- Byte order: the low byte is at the lower address.
- The wait counter clears on every MemReady and on entering FETCH_LO. If the counter equals MAX_WAIT with MemReady=0 in a fetch state, the state goes to FAULT and TimeoutErr←1.
- ISSUE: hold until ExecDone.
  - On ExecDone with Branch=1, PC←BranchTarget.
  - Next state is FETCH_LO if Enable=1, otherwise IDLE.
  - Branch without ExecDone is ignored.
- FAULT: MemRead=0, IR_Write=0. The state and TimeoutErr persist until Reset.
- PC arithmetic is modulo 2^ADDR_W: PC=all-ones increments to 0, so an instruction may straddle the wrap.
- Deasserting Enable mid-fetch has no effect; the current instruction completes through ISSUE.
- Reset during FETCH_HI or ISSUE abandons the instruction. IR_Write is suppressed in the Reset cycle, and IR contents are don't-care afterwards.

## Timing
- Zero-wait fetch: FETCH_LO in cycle n, FETCH_HI in n+1, InstrValid=1 from n+2.
- Each cycle MemReady is low adds one cycle of latency to the fetch.
- Back-to-back throughput with ExecDone in the first ISSUE cycle and Enable=1: one instruction per 3 cycles.
- The PC update is visible on MemAddr the cycle after the accepting edge.
- Fault timing: with MemReady held low, FAULT is entered on the (MAX_WAIT+1)th fetch-state cycle. TimeoutErr is high the following cycle.
- Reset value of every output:
  - PC=MemAddr=RESET_PC.
  - MemRead, IR_LH, IR_Write, InstrValid and TimeoutErr are all 0.

## Test plan
- Reset, Enable=1, MemReady=1 always, memory holds 0x34 at address 0 and 0x12 at address 1, ExecDone pulsed in ISSUE:
  - IR_Write at cycles 1–2 with IR_LH=0 then 1, so IR=0x1234.
  - InstrValid at cycle 3, next MemAddr=2, repeating every 3 cycles.
- MemReady low for 3 cycles in FETCH_LO and 2 in FETCH_HI:
  - InstrValid is delayed by exactly 5 cycles.
  - IR_Write pulses only on MemReady cycles.
  - TimeoutErr stays 0.
- MemReady stuck low with MAX_WAIT=15:
  - FAULT is entered after 16 FETCH_LO cycles, TimeoutErr=1 and MemRead=0.
  - It persists until Reset, after which PC=RESET_PC.
- Branch=1 with ExecDone, BranchTarget=0x80:
  - Next fetch addresses are 0x80 then 0x81.
  - Branch=1 without ExecDone leaves PC unchanged.
- PC at 0xFF entering FETCH_LO: fetch addresses are 0xFF then 0x00, and PC=0x01 in ISSUE.
- Enable dropped in FETCH_HI: the instruction completes to ISSUE, then the block goes to IDLE after ExecDone.
- Reset asserted in FETCH_HI with MemReady=1: IR_Write=0 that cycle, then IDLE with PC=RESET_PC.
